// File: rtl/reg_bank_pkg.sv
// Shared types and address decode for the multi-host register bank.
// Imported by the arbiter-fronted top and its testbench.
package reg_bank_pkg;

  typedef enum logic {
    ACC_READ,
    ACC_WRITE
  } acc_e;

  typedef enum logic [1:0] {
    REG_CFG,
    REG_STATUS,
    REG_INVALID
  } region_e;

  function automatic region_e decode_region(
    input int addr,
    input int num_cfg,
    input int num_status
  );
    if (addr < num_cfg)
      return REG_CFG;
    if (addr < num_cfg + num_status)
      return REG_STATUS;
    return REG_INVALID;
  endfunction

endpackage

// File: rtl/reg_bank_mhost_rr_arbiter.sv
// Round-robin arbiter; the search starts one past the last winner.
// Holds the rotating start pointer, cleared to host 0 on reset.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          ena,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant_comb,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] start_q;
  logic          found;

  always_comb begin
    grant_comb = '0;
    grant_idx  = '0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int h = 0; h < N; h++) begin
        if (ena && !found && req[h] &&
            ((int'(start_q) + i) % N) == h) begin
          found         = 1'b1;
          grant_comb[h] = 1'b1;
          grant_idx     = IW'(h);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      start_q <= '0;
    else if (found)
      start_q <= (grant_idx == IW'(N - 1)) ?
                 '0 : grant_idx + IW'(1);
  end

endmodule

// File: rtl/reg_bank_mhost.sv
// Multi-host config/status register bank behind a round-robin arbiter.
// Config R/W, live or sticky-W1C status, registered one-cycle response.
module reg_bank_mhost
  import reg_bank_pkg::*;
#(
  parameter int NUM_HOSTS  = 2,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 4,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_CFG + NUM_STATUS),
  parameter logic [NUM_STATUS-1:0] STICKY_MASK = '0
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_HOSTS-1:0]            host_req,
  input  logic [NUM_HOSTS-1:0]            host_wr_rdn,
  input  logic [NUM_HOSTS*ADDR_WIDTH-1:0] host_addr,
  input  logic [NUM_HOSTS*REG_WIDTH-1:0]  host_wdata,
  output logic [NUM_HOSTS-1:0]            host_gnt,
  output logic [REG_WIDTH-1:0]            host_rdata,
  output logic                            host_err,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_in,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_CFG-1:0]              cfg_wr_pulse
);

  localparam int IW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;

  logic [NUM_HOSTS-1:0]  elig;
  logic [NUM_HOSTS-1:0]  grant_comb;
  logic [IW-1:0]         grant_idx;
  logic                  go;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wr;
  logic [REG_WIDTH-1:0]  sel_wdata;
  int                    addr_i;
  region_e               region;
  acc_e                  acc;
  logic                  wr_cfg;
  logic                  wr_st;
  logic [REG_WIDTH-1:0]  rd_val;
  logic [NUM_CFG-1:0]    pulse_d;
  logic [REG_WIDTH-1:0]  cfg_q  [NUM_CFG];
  logic [REG_WIDTH-1:0]  st_q   [NUM_STATUS];
  logic [REG_WIDTH-1:0]  st_clr [NUM_STATUS];

  // A host holding its grant this cycle is not eligible again yet
  assign elig = host_req & ~host_gnt;

  rr_arbiter #(
    .N  (NUM_HOSTS),
    .IW (IW)
  ) u_arb (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .req        (elig),
    .grant_comb (grant_comb),
    .grant_idx  (grant_idx)
  );

  assign go = |grant_comb;

  always_comb begin
    sel_addr  = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int h = 0; h < NUM_HOSTS; h++) begin
      if (IW'(h) == grant_idx) begin
        sel_addr  = host_addr[h*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wr    = host_wr_rdn[h];
        sel_wdata = host_wdata[h*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign addr_i = 32'(sel_addr);
  assign region = decode_region(addr_i, NUM_CFG, NUM_STATUS);
  assign acc    = acc_e'(sel_wr);
  assign wr_cfg = go && acc == ACC_WRITE && region == REG_CFG;
  assign wr_st  = go && acc == ACC_WRITE && region == REG_STATUS;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      region == REG_CFG: begin
        for (int c = 0; c < NUM_CFG; c++)
          if (addr_i == c)
            rd_val = cfg_q[c];
      end
      region == REG_STATUS: begin
        for (int s = 0; s < NUM_STATUS; s++)
          if (addr_i == NUM_CFG + s)
            rd_val = STICKY_MASK[s] ? st_q[s] :
                     status_in[s*REG_WIDTH +: REG_WIDTH];
      end
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    for (int c = 0; c < NUM_CFG; c++)
      pulse_d[c] = wr_cfg && addr_i == c;
  end

  always_comb begin
    for (int s = 0; s < NUM_STATUS; s++)
      st_clr[s] = (wr_st && addr_i == NUM_CFG + s) ?
                  sel_wdata : '0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int c = 0; c < NUM_CFG; c++)
        cfg_q[c] <= '0;
    end else if (wr_cfg) begin
      for (int c = 0; c < NUM_CFG; c++)
        if (addr_i == c)
          cfg_q[c] <= sel_wdata;
    end
  end

  // Capture is OR'ed in after the clear so a same-cycle set wins
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < NUM_STATUS; s++)
        st_q[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_STATUS; s++)
        if (STICKY_MASK[s])
          st_q[s] <= (st_q[s] & ~st_clr[s]) |
                     status_in[s*REG_WIDTH +: REG_WIDTH];
        else
          st_q[s] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      host_gnt     <= '0;
      host_rdata   <= '0;
      host_err     <= 1'b0;
      cfg_wr_pulse <= '0;
    end else begin
      host_gnt     <= grant_comb;
      host_rdata   <= (go && acc == ACC_READ) ? rd_val : '0;
      host_err     <= go && region == REG_INVALID;
      cfg_wr_pulse <= pulse_d;
    end
  end

  for (genvar c = 0; c < NUM_CFG; c++) begin : g_cfg_out
    assign config_regs[c*REG_WIDTH +: REG_WIDTH] = cfg_q[c];
  end

endmodule

// File: tb/tb_reg_bank_mhost.sv
// Directed bench for reg_bank_mhost: 2 hosts, 8 config, 4 status.
// Status 1 sticky, status 0 live; expected values hand-computed.
module tb_reg_bank_mhost;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        ena = 1'b1;
  logic [1:0]  host_req = '0;
  logic [1:0]  host_wr_rdn = '0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [1:0]  host_gnt;
  logic [7:0]  host_rdata;
  logic        host_err;
  logic [31:0] status_in = '0;
  logic [63:0] config_regs;
  logic [7:0]  cfg_wr_pulse;

  int total = 0;
  int bad = 0;

  reg_bank_mhost #(
    .NUM_HOSTS   (2),
    .NUM_CFG     (8),
    .NUM_STATUS  (4),
    .REG_WIDTH   (8),
    .STICKY_MASK (4'b0010)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .host_req     (host_req),
    .host_wr_rdn  (host_wr_rdn),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rdata   (host_rdata),
    .host_err     (host_err),
    .status_in    (status_in),
    .config_regs  (config_regs),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic h0(input logic wr,
                    input logic [3:0] a,
                    input logic [7:0] d);
    host_req[0]      = 1'b1;
    host_wr_rdn[0]   = wr;
    host_addr[3:0]   = a;
    host_wdata[7:0]  = d;
  endtask

  task automatic idle();
    host_req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_gnt", 64'(host_gnt), 64'h0);
    check("rst_rdata", 64'(host_rdata), 64'h0);
    check("rst_err", 64'(host_err), 64'h0);
    check("rst_cfg", config_regs, 64'h0);
    check("rst_pulse", 64'(cfg_wr_pulse), 64'h0);
    rstb = 1'b1;
    tick();

    h0(1'b1, 4'd3, 8'hA5);
    tick();
    idle();
    check("wr_gnt", 64'(host_gnt), 64'h1);
    check("wr_pulse", 64'(cfg_wr_pulse), 64'h08);
    check("wr_cfg3", 64'(config_regs[31:24]), 64'hA5);
    check("wr_err", 64'(host_err), 64'h0);
    tick();
    check("wr_gnt_end", 64'(host_gnt), 64'h0);
    check("wr_pulse_end", 64'(cfg_wr_pulse), 64'h0);

    h0(1'b0, 4'd3, 8'h00);
    tick();
    idle();
    check("rd_gnt", 64'(host_gnt), 64'h1);
    check("rd_cfg3", 64'(host_rdata), 64'hA5);
    tick();

    host_req    = 2'b11;
    host_wr_rdn = 2'b00;
    host_addr   = {4'd1, 4'd0};
    tick();
    check("rr_0", 64'(host_gnt), 64'h2);
    tick();
    check("rr_1", 64'(host_gnt), 64'h1);
    tick();
    check("rr_2", 64'(host_gnt), 64'h2);
    tick();
    check("rr_3", 64'(host_gnt), 64'h1);
    idle();
    tick();
    check("rr_end", 64'(host_gnt), 64'h0);

    status_in[15:8] = 8'h81;
    tick();
    status_in = '0;
    h0(1'b0, 4'd9, 8'h00);
    tick();
    idle();
    check("stk_rd", 64'(host_rdata), 64'h81);
    check("stk_rd_err", 64'(host_err), 64'h0);
    tick();

    h0(1'b1, 4'd9, 8'h01);
    tick();
    idle();
    check("stk_w1c_gnt", 64'(host_gnt), 64'h1);
    tick();
    h0(1'b0, 4'd9, 8'h00);
    tick();
    idle();
    check("stk_w1c_rd", 64'(host_rdata), 64'h80);
    tick();

    h0(1'b1, 4'd9, 8'h80);
    status_in[15:8] = 8'h80;
    tick();
    idle();
    status_in = '0;
    tick();
    h0(1'b0, 4'd9, 8'h00);
    tick();
    idle();
    check("stk_setwins", 64'(host_rdata), 64'h80);
    tick();

    status_in[7:0] = 8'h5A;
    h0(1'b0, 4'd8, 8'h00);
    tick();
    idle();
    check("live_rd", 64'(host_rdata), 64'h5A);
    tick();
    h0(1'b1, 4'd8, 8'hFF);
    tick();
    idle();
    check("live_wr_err", 64'(host_err), 64'h0);
    check("live_wr_pulse", 64'(cfg_wr_pulse), 64'h0);
    status_in = '0;
    tick();

    h0(1'b0, 4'd13, 8'h00);
    tick();
    idle();
    check("inv_rd_gnt", 64'(host_gnt), 64'h1);
    check("inv_rd_data", 64'(host_rdata), 64'h0);
    check("inv_rd_err", 64'(host_err), 64'h1);
    tick();
    h0(1'b1, 4'd12, 8'hFF);
    tick();
    idle();
    check("inv_wr_err", 64'(host_err), 64'h1);
    check("inv_wr_cfg", config_regs, 64'h00000000_A5000000);
    check("inv_wr_pulse", 64'(cfg_wr_pulse), 64'h0);
    tick();
    check("err_clear", 64'(host_err), 64'h0);

    ena = 1'b0;
    h0(1'b0, 4'd3, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ena_stall", 64'(host_gnt), 64'h0);
    end
    ena = 1'b1;
    tick();
    idle();
    check("ena_resume_gnt", 64'(host_gnt), 64'h1);
    check("ena_resume_rd", 64'(host_rdata), 64'hA5);
    tick();

    h0(1'b1, 4'd5, 8'h77);
    rstb = 1'b0;
    tick();
    idle();
    tick();
    rstb = 1'b1;
    check("rst_mid_pulse", 64'(cfg_wr_pulse), 64'h0);
    check("rst_mid_gnt", 64'(host_gnt), 64'h0);
    check("rst_mid_cfg", config_regs, 64'h0);
    tick();
    host_req    = 2'b11;
    host_wr_rdn = 2'b00;
    host_addr   = {4'd1, 4'd0};
    tick();
    idle();
    check("rst_ptr", 64'(host_gnt), 64'h1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
